// File: rtl/spn_sbox_pkg.sv
// Shared SPN primitives: 4-bit S-box pair, nibble/bit transpose, op and FSM encodings.
// Pure constants and functions; no state.
package spn_sbox_pkg;

  localparam int BLK_W = 16;

  localparam logic [3:0] SBOX [16] = '{
    4'hE, 4'h4, 4'hD, 4'h1, 4'h2, 4'hF, 4'hB, 4'h8,
    4'h3, 4'hA, 4'h6, 4'hC, 4'h5, 4'h9, 4'h0, 4'h7
  };

  localparam logic [3:0] SBOX_INV [16] = '{
    4'hE, 4'h3, 4'h4, 4'h8, 4'h1, 4'hC, 4'hA, 4'hF,
    4'h7, 4'hD, 4'h9, 4'h6, 4'hB, 4'h2, 4'h0, 4'h5
  };

  typedef enum logic {SPN_ENC, SPN_DEC} spn_op_e;

  typedef enum logic [1:0] {IDLE, RUN, DONE} spn_state_e;

  // Bit b of nibble j lands on bit j of nibble b; applying it twice is identity.
  function automatic logic [BLK_W-1:0] spn_perm(input logic [BLK_W-1:0] v);
    logic [BLK_W-1:0] p;
    p = '0;
    for (int j = 0; j < 4; j++) begin
      for (int b = 0; b < 4; b++) begin
        p[4*b+j] = v[4*j+b];
      end
    end
    return p;
  endfunction

  function automatic logic [BLK_W-1:0] spn_sub(input logic [BLK_W-1:0] v, input logic inv);
    logic [BLK_W-1:0] s;
    s = '0;
    for (int j = 0; j < 4; j++) begin
      s[4*j +: 4] = inv ? SBOX_INV[v[4*j +: 4]] : SBOX[v[4*j +: 4]];
    end
    return s;
  endfunction

endpackage

// File: rtl/spn_round_step.sv
// One SPN round step (encrypt or inverse), purely combinational.
// key_a/key_b meaning depends on op: enc uses K[r]/K[N], dec uses K[N]/K[N-1-r].
module spn_round_step
  import spn_sbox_pkg::*;
(
  input  logic [BLK_W-1:0] i_v,
  input  spn_op_e          i_op,
  input  logic             i_is_first,
  input  logic             i_is_last,
  input  logic [BLK_W-1:0] i_key_a,
  input  logic [BLK_W-1:0] i_key_b,
  output logic [BLK_W-1:0] o_v
);

  always_comb begin
    o_v = i_v;
    if (i_op == SPN_ENC) begin
      if (i_is_last) o_v = spn_sub(i_v ^ i_key_a, 1'b0) ^ i_key_b;
      else           o_v = spn_perm(spn_sub(i_v ^ i_key_a, 1'b0));
    end else begin
      // First inverse step peels the final whitening key; later steps undo P then S.
      if (i_is_first) o_v = spn_sub(i_v ^ i_key_a, 1'b1) ^ i_key_b;
      else            o_v = spn_sub(spn_perm(i_v), 1'b1) ^ i_key_b;
    end
  end

endmodule

// File: rtl/spn_iter_cu.sv
// Iterative 16-bit SPN enc/dec unit: one round per clock, result N_ROUNDS cycles after accept.
// Result holds while out_ready is low; a new request may be accepted on the retiring edge.
module spn_iter_cu
  import spn_sbox_pkg::*;
#(
  parameter  int N_ROUNDS = 3,
  localparam int KEY_W    = 16*(N_ROUNDS+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [15:0]      in_data,
  input  logic [KEY_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_op,
  output logic             busy
);

  localparam int CW = $clog2(N_ROUNDS+1);

  if (N_ROUNDS < 1 || N_ROUNDS > 8) begin : g_bad_n_rounds
    $error("spn_iter_cu: N_ROUNDS must be in 1..8");
  end

  spn_state_e       r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [BLK_W-1:0] r_v;
  logic [KEY_W-1:0] r_key;
  logic             r_op;
  logic             w_accept, w_is_first, w_is_last;
  logic [BLK_W-1:0] w_v_nxt, w_key_a, w_key_b, w_enc_a, w_dec_b, w_key_top;

  assign w_is_first = (r_cnt == '0);
  assign w_is_last  = (r_cnt == CW'(N_ROUNDS-1));
  assign w_accept   = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_is_last) w_state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        in_ready  = rst_n && out_ready;
        if (out_ready) w_state_nxt = (in_valid && rst_n) ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_key_top = r_key[BLK_W*N_ROUNDS +: BLK_W];

  // Encrypt walks keys upward from K[0]; decrypt walks downward from K[N-1].
  always_comb begin
    w_enc_a = r_key[0 +: BLK_W];
    w_dec_b = r_key[BLK_W*(N_ROUNDS-1) +: BLK_W];
    for (int i = 0; i < N_ROUNDS; i++) begin
      if (r_cnt == CW'(i)) begin
        w_enc_a = r_key[BLK_W*i +: BLK_W];
        w_dec_b = r_key[BLK_W*(N_ROUNDS-1-i) +: BLK_W];
      end
    end
  end

  assign w_key_a = r_op ? w_key_top : w_enc_a;
  assign w_key_b = r_op ? w_dec_b   : w_key_top;

  spn_round_step u_step (
    .i_v        (r_v),
    .i_op       (spn_op_e'(r_op)),
    .i_is_first (w_is_first),
    .i_is_last  (w_is_last),
    .i_key_a    (w_key_a),
    .i_key_b    (w_key_b),
    .o_v        (w_v_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_key <= '0;
      r_op  <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_v   <= in_data;
      r_key <= in_key;
      r_op  <= in_op;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_v <= w_v_nxt;
      if (!w_is_last) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign out_data = r_v;
  assign out_op   = r_op;

endmodule

// File: tb/tb_spn_iter_cu.sv
// Directed bench for spn_iter_cu at N_ROUNDS = 1, 2 and 3 with hand-computed vectors.
// Instance index n equals its round count.
module tb_spn_iter_cu;

  logic        clk;
  logic        rst_n;
  logic        ivld   [1:3];
  logic        irdy   [1:3];
  logic        iop    [1:3];
  logic [15:0] idat   [1:3];
  logic [63:0] ikey   [1:3];
  logic        ovld   [1:3];
  logic        oready [1:3];
  logic [15:0] odat   [1:3];
  logic        oop    [1:3];
  logic        obusy  [1:3];

  int n_tests = 0;
  int n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spn_iter_cu #(.N_ROUNDS(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivld[1]), .in_ready(irdy[1]), .in_op(iop[1]),
    .in_data(idat[1]), .in_key(ikey[1][31:0]), .out_valid(ovld[1]), .out_ready(oready[1]),
    .out_data(odat[1]), .out_op(oop[1]), .busy(obusy[1])
  );

  spn_iter_cu #(.N_ROUNDS(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivld[2]), .in_ready(irdy[2]), .in_op(iop[2]),
    .in_data(idat[2]), .in_key(ikey[2][47:0]), .out_valid(ovld[2]), .out_ready(oready[2]),
    .out_data(odat[2]), .out_op(oop[2]), .busy(obusy[2])
  );

  spn_iter_cu #(.N_ROUNDS(3)) u_n3 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivld[3]), .in_ready(irdy[3]), .in_op(iop[3]),
    .in_data(idat[3]), .in_key(ikey[3][63:0]), .out_valid(ovld[3]), .out_ready(oready[3]),
    .out_data(odat[3]), .out_op(oop[3]), .busy(obusy[3])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance n; payload is scrambled after accept to prove latching.
  task automatic run(input int n, input logic op, input logic [15:0] data, input logic [63:0] key,
                     input bit chk_dat, input logic [15:0] exp, input bit scramble_key,
                     output logic [15:0] res);
    int w;
    ivld[n] = 1'b1; iop[n] = op; idat[n] = data; ikey[n] = key; oready[n] = 1'b1;
    #1;
    w = 0;
    while (!irdy[n] && w < 20) begin tick(); w++; end
    chk("in_ready_before_accept", irdy[n], 1);
    tick();
    ivld[n] = 1'b0; iop[n] = ~op; idat[n] = 16'($urandom);
    if (scramble_key) ikey[n] = {$urandom, $urandom};
    #1;
    chk("busy_after_accept", obusy[n], 1);
    chk("in_ready_in_run", irdy[n], 0);
    w = 0;
    while (!ovld[n] && w < 20) begin tick(); w++; end
    chk("latency", w, n);
    if (chk_dat) chk("out_data", odat[n], exp);
    chk("out_op", oop[n], op);
    res = odat[n];
    tick();
    chk("retired", ovld[n], 0);
  endtask

  initial begin
    logic [15:0] c, r, d;
    logic [63:0] k;
    int w;

    rst_n = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      ivld[i] = 1'b1; iop[i] = 1'b0; idat[i] = 16'h1234; ikey[i] = '0; oready[i] = 1'b1;
    end
    #1;
    chk("rst_in_ready_comb", irdy[3], 0);
    repeat (3) begin
      tick();
      chk("rst_out_valid", ovld[3], 0);
      chk("rst_out_data", odat[3], 16'h0000);
      chk("rst_busy", obusy[3], 0);
      chk("rst_in_ready", irdy[3], 0);
      chk("rst_n1_busy", obusy[1], 0);
    end
    for (int i = 1; i <= 3; i++) ivld[i] = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle_busy", obusy[3], 0);
    chk("post_rst_idle_ready", irdy[3], 1);
    chk("post_rst_no_valid", ovld[3], 0);

    run(1, 1'b0, 16'h0000, 64'h0, 1, 16'hEEEE, 0, r);
    run(1, 1'b0, 16'h0123, 64'h89AB_4567, 1, 16'hAB89, 0, r);
    run(1, 1'b1, 16'hAB89, 64'h89AB_4567, 1, 16'h0123, 0, r);

    run(2, 1'b0, 16'h0000, 64'h0, 1, 16'h777E, 0, r);
    run(2, 1'b1, 16'h777E, 64'h0, 1, 16'h0000, 0, r);
    run(2, 1'b0, 16'h0000, 64'hFFFF_0000_1111, 1, 16'h1811, 0, r);
    run(2, 1'b1, 16'h1811, 64'hFFFF_0000_1111, 1, 16'h0000, 0, r);

    run(3, 1'b0, 16'h0000, 64'h0, 1, 16'h4770, 0, r);
    run(3, 1'b1, 16'h4770, 64'h0, 1, 16'h0000, 0, r);
    run(3, 1'b0, 16'h0000, 64'h0, 1, 16'h4770, 1, r);

    for (int t = 0; t < 1000; t++) begin
      d = 16'($urandom);
      k = {$urandom, $urandom};
      run(3, 1'b0, d, k, 0, 16'h0, 0, c);
      run(3, 1'b1, c, k, 1, d, (t % 4) == 0, r);
    end

    // Back-pressure: hold result, then retire and accept on the same edge.
    ivld[3] = 1'b1; iop[3] = 1'b0; idat[3] = 16'h0000; ikey[3] = '0; oready[3] = 1'b0;
    tick();
    ivld[3] = 1'b0;
    repeat (3) tick();
    chk("bp_valid", ovld[3], 1);
    chk("bp_data", odat[3], 16'h4770);
    ivld[3] = 1'b1; iop[3] = 1'b1; idat[3] = 16'h4770;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_data", odat[3], 16'h4770);
      chk("bp_hold_valid", ovld[3], 1);
      chk("bp_hold_op", oop[3], 0);
      chk("bp_in_ready_low", irdy[3], 0);
    end
    oready[3] = 1'b1;
    #1;
    chk("bp_in_ready_release", irdy[3], 1);
    tick();
    ivld[3] = 1'b0;
    chk("bp_valid_drop", ovld[3], 0);
    chk("bp_busy_new", obusy[3], 1);
    w = 0;
    while (!ovld[3] && w < 20) begin tick(); w++; end
    chk("bp_next_latency", w, 3);
    chk("bp_next_data", odat[3], 16'h0000);
    chk("bp_next_op", oop[3], 1);
    tick();

    // Reset while the counter is at r=1.
    ivld[3] = 1'b1; iop[3] = 1'b0; idat[3] = 16'h0000; ikey[3] = '0;
    tick();
    ivld[3] = 1'b0;
    tick();
    chk("mid_busy", obusy[3], 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", irdy[3], 0);
    tick();
    chk("mid_rst_busy", obusy[3], 0);
    chk("mid_rst_valid", ovld[3], 0);
    chk("mid_rst_data", odat[3], 16'h0000);
    tick();
    rst_n = 1'b1;
    w = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ovld[3] || obusy[3]) w++;
    end
    chk("mid_rst_no_pulse", w, 0);
    chk("mid_rst_idle_ready", irdy[3], 1);
    run(3, 1'b0, 16'h0000, 64'h0, 1, 16'h4770, 0, r);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
